// File: rtl/call_stack_controller.sv
// Hardware return stack for call/ret: pushes {PC, flags}, and restores a ret as flags then PC.
// Optional CALL_STACK_WRAP_EN: a call while full overwrites the oldest entry (circular stack).
module call_stack_controller #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned FLAG_WIDTH = 4,
  parameter int unsigned DEPTH      = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_call,
  input  logic                          in_ret,
  input  logic [PC_WIDTH-1:0]           in_pc,
  input  logic [FLAG_WIDTH-1:0]         in_flags,
  output logic [FLAG_WIDTH-1:0]         out_flags,
  output logic                          out_flags_load,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic                          out_pc_load,
  output logic                          out_busy,
  output logic                          out_done,
  output logic [$clog2(DEPTH+1)-1:0]    out_depth,
  output logic                          out_overflow,
  output logic                          out_underflow
);

  localparam int unsigned DepW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [DepW-1:0] Full   = DepW'(DEPTH);
  localparam logic [DepW-1:0] LastSp = DepW'(DEPTH - 1);
  localparam logic [DepW-1:0] One    = DepW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StCallAck,
    StRetFlags,
    StRetPc,
    StFaultAck
  } state_e;

  state_e                r_state, w_state_next;
  logic [DepW-1:0]       r_sp, w_sp_next;
  logic [DepW-1:0]       r_depth, w_depth_next;
  logic                  r_ovf, w_ovf_next;
  logic                  r_unf, w_unf_next;
  logic                  w_push;
  logic                  w_full;
  logic [DepW-1:0]       w_sp_inc, w_sp_dec;
  logic [AddrW-1:0]      w_idx;

  logic [PC_WIDTH-1:0]   r_pc_mem [DEPTH];
  logic [FLAG_WIDTH-1:0] r_fl_mem [DEPTH];

  assign w_full = (r_depth == Full);
  assign w_idx  = r_sp[AddrW-1:0];

`ifdef CALL_STACK_WRAP_EN
  // sp is the physical slot of the next push and wraps modulo DEPTH.
  assign w_sp_inc = (r_sp == LastSp) ? '0 : r_sp + One;
  assign w_sp_dec = (r_sp == '0) ? LastSp : r_sp - One;
`else
  assign w_sp_inc = r_sp + One;
  assign w_sp_dec = r_sp - One;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sp    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sp    <= w_sp_next;
      r_depth <= w_depth_next;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
    end
  end

  // Stack storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[w_idx] <= in_pc;
      r_fl_mem[w_idx] <= in_flags;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sp_next    = r_sp;
    w_depth_next = r_depth;
    w_ovf_next   = r_ovf;
    w_unf_next   = r_unf;
    w_push       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_call) begin
          w_state_next = StCallAck;
          if (!w_full) begin
            w_push       = 1'b1;
            w_sp_next    = w_sp_inc;
            w_depth_next = r_depth + One;
          end else begin
            w_ovf_next = 1'b1;
`ifdef CALL_STACK_WRAP_EN
            w_push    = 1'b1;
            w_sp_next = w_sp_inc;
`endif
          end
        end else if (in_ret) begin
          if (r_depth != '0) begin
            w_sp_next    = w_sp_dec;
            w_depth_next = r_depth - One;
            w_state_next = StRetFlags;
          end else begin
            w_unf_next   = 1'b1;
            w_state_next = StFaultAck;
          end
        end
      end
      StCallAck:  w_state_next = StIdle;
      StRetFlags: w_state_next = StRetPc;
      StRetPc:    w_state_next = StIdle;
      StFaultAck: w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // sp already points at the popped entry during both restore states.
  assign out_flags_load = (r_state == StRetFlags);
  assign out_pc_load    = (r_state == StRetPc);
  assign out_flags      = out_flags_load ? r_fl_mem[w_idx] : '0;
  assign out_pc         = out_pc_load ? r_pc_mem[w_idx] : '0;
  assign out_busy       = (r_state != StIdle);
  assign out_done       = (r_state == StCallAck) || (r_state == StRetPc) ||
                          (r_state == StFaultAck);
  assign out_depth      = r_depth;
  assign out_overflow   = r_ovf;
  assign out_underflow  = r_unf;

endmodule

// File: tb/tb_call_stack_controller.sv
// Cycle-by-cycle vector table for call_stack_controller plus a hand-written mid-ret reset check.
module tb_call_stack_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_call, in_ret;
  logic [15:0] in_pc;
  logic [3:0]  in_flags;
  logic [3:0]  out_flags;
  logic        out_flags_load;
  logic [15:0] out_pc;
  logic        out_pc_load, out_busy, out_done;
  logic [2:0]  out_depth;
  logic        out_overflow, out_underflow;

  int errors = 0;
  int checks = 0;

  call_stack_controller #(.PC_WIDTH(16), .FLAG_WIDTH(4), .DEPTH(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_call       (in_call),
    .in_ret        (in_ret),
    .in_pc         (in_pc),
    .in_flags      (in_flags),
    .out_flags     (out_flags),
    .out_flags_load(out_flags_load),
    .out_pc        (out_pc),
    .out_pc_load   (out_pc_load),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_depth     (out_depth),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  // One row = inputs held for one cycle and the outputs expected after that edge.
  typedef struct {
    logic        call, ret;
    logic [15:0] pc;
    logic [3:0]  fl;
    logic        done, fload, pload, busy, ovf, unf;
    logic [2:0]  dep;
    logic [3:0]  efl;
    logic [15:0] epc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t row(logic call, logic ret, logic [15:0] pc, logic [3:0] fl,
                               logic done, logic fload, logic pload, logic busy,
                               logic ovf, logic unf, logic [2:0] dep,
                               logic [3:0] efl, logic [15:0] epc);
    vec_t v;
    v.call = call; v.ret = ret; v.pc = pc; v.fl = fl;
    v.done = done; v.fload = fload; v.pload = pload; v.busy = busy;
    v.ovf = ovf; v.unf = unf; v.dep = dep; v.efl = efl; v.epc = epc;
    return v;
  endfunction

  // Call: CALL_ACK with done, then back to idle. ret_too drives a simultaneous ret.
  task automatic t_call(input logic [15:0] pc, input logic [3:0] fl, input logic [2:0] dep,
                        input logic ovf, input logic unf, input logic ret_too);
    vq.push_back(row(1, ret_too, pc, fl, 1, 0, 0, 1, ovf, unf, dep, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, ovf, unf, dep, 0, 0));
  endtask

  // Ret: flags load, then PC load with done, then idle. noise pulses in_call in RET_FLAGS.
  task automatic t_ret(input logic [15:0] pc, input logic [3:0] fl, input logic [2:0] dep,
                       input logic ovf, input logic unf, input logic noise);
    vq.push_back(row(0, 1, 0, 0, 0, 1, 0, 1, ovf, unf, dep, fl, 0));
    vq.push_back(row(noise, 0, 16'hDEAD, 4'hD, 1, 0, 1, 1, ovf, unf, dep, 0, pc));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, ovf, unf, dep, 0, 0));
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; in_call = 0; in_ret = 0; in_pc = '0; in_flags = '0;

    // Test 1: single call/ret round trip.
    t_call(16'h0123, 4'b1010, 1, 0, 0, 0);
    t_ret (16'h0123, 4'b1010, 0, 0, 0, 0);
    // Tests 2/3: fill, overflow with 0x60, drain.
    for (int i = 1; i <= 5; i++) t_call(16'(i * 16), 4'(i), 3'(i), 0, 0, 0);
    t_call(16'h0060, 4'h6, 5, 1, 0, 0);
`ifdef CALL_STACK_WRAP_EN
    for (int i = 6; i >= 2; i--) t_ret(16'(i * 16), 4'(i), 3'(i - 2), 1, 0, 0);
`else
    for (int i = 5; i >= 1; i--) t_ret(16'(i * 16), 4'(i), 3'(i - 1), 1, 0, 0);
`endif
    // Test 4: ret on empty stack.
    vq.push_back(row(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // Test 5: call+ret together at depth 1, then a call pulsed during RET_FLAGS.
    t_call(16'h0070, 4'h7, 1, 1, 1, 0);
    t_call(16'h0080, 4'h8, 2, 1, 1, 1);
    t_ret (16'h0080, 4'h8, 1, 1, 1, 1);
    t_call(16'h0090, 4'h9, 2, 1, 1, 0);

    #1;
    chk("rst_ctrl", {out_done, out_flags_load, out_pc_load, out_busy, out_overflow,
                     out_underflow, out_depth}, '0);
    chk("rst_data", {out_flags, out_pc}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      v = vq[i];
      in_call = v.call; in_ret = v.ret; in_pc = v.pc; in_flags = v.fl;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_ctrl", i),
          {out_done, out_flags_load, out_pc_load, out_busy, out_overflow, out_underflow,
           out_depth},
          {v.done, v.fload, v.pload, v.busy, v.ovf, v.unf, v.dep});
      if (v.fload) chk($sformatf("row%0d_flags", i), 32'(out_flags), 32'(v.efl));
      if (v.pload) chk($sformatf("row%0d_pc", i), 32'(out_pc), 32'(v.epc));
    end

    // Test 6: reset asserted while in RET_FLAGS from depth 2.
    in_call = 0; in_ret = 1;
    @(posedge clk);
    @(negedge clk);
    in_ret = 0;
    chk("t6_fload_before", {out_flags_load, 3'(out_depth)}, {1'b1, 3'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_after_rst", {out_flags_load, out_pc_load, out_busy, out_done, out_overflow,
                         out_underflow, out_depth}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t6_quiet%0d", c), {out_flags_load, out_pc_load, out_busy, out_depth},
          '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
